pipelined_cla_addsub: RTL and testbench

//  Parametrised, pipelined carry-look-ahead adder/subtractor for the ALU datapath.

---
 rtl/pipelined_cla_addsub.sv | 147 ++++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_addsub.sv
// Elastic, STAGES-deep carry-look-ahead adder/subtractor. Each stage resolves one
// WIDTH/STAGES slice from BLOCK-bit CLA groups, using the carry registered by the stage before.

module pipelined_cla_addsub_slice #(
    parameter int SW    = 16,
    parameter int BLOCK = 4
) (
    input  logic [SW-1:0] i_a,
    input  logic [SW-1:0] i_b,
    input  logic          i_cin,
    output logic [SW-1:0] o_sum,
    output logic          o_cout,
    output logic          o_cmsb
);
    localparam int NG = SW / BLOCK;

    logic [SW-1:0] w_g, w_p, w_c;
    logic [NG-1:0] w_grp_g, w_grp_p;
    logic [NG:0]   w_gc;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin
        w_grp_g = '0;
        w_grp_p = '1;
        w_gc    = '0;
        w_c     = '0;
        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < BLOCK; i++) begin
                w_grp_g[j] = w_g[j*BLOCK+i] | (w_p[j*BLOCK+i] & w_grp_g[j]);
                w_grp_p[j] = w_grp_p[j] & w_p[j*BLOCK+i];
            end
        end
        // Group lookahead: one carry per BLOCK-bit group, then bit carries inside each group.
        w_gc[0] = i_cin;
        for (int j = 0; j < NG; j++)
            w_gc[j+1] = w_grp_g[j] | (w_grp_p[j] & w_gc[j]);
        for (int j = 0; j < NG; j++) begin
            w_c[j*BLOCK] = w_gc[j];
            for (int i = 1; i < BLOCK; i++)
                w_c[j*BLOCK+i] = w_g[j*BLOCK+i-1] | (w_p[j*BLOCK+i-1] & w_c[j*BLOCK+i-1]);
        end
    end

    assign o_sum  = w_p ^ w_c;
    assign o_cout = w_gc[NG];
    assign o_cmsb = w_c[SW-1];
endmodule

module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int SW = WIDTH / STAGES;

    // Operands above the current slice ride along; partial sum holds the finished lower slices.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] bx;
        logic [WIDTH-1:0] s;
        logic             c;
    } beat_t;

    beat_t [STAGES-1:0]        r_pipe;
    beat_t [STAGES-1:0]        w_src, w_nxt;
    logic  [STAGES-1:0]        r_vld, w_vld_in, w_rdy;
    logic  [STAGES-1:0][SW-1:0] w_ssum;
    logic  [STAGES-1:0]        w_scout, w_scmsb;
    logic                      r_ovf, r_zero;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_src[k]    = '{a: a, bx: (sub ? ~b : b), s: '0, c: sub ^ cin};
            assign w_vld_in[k] = in_valid;
        end else begin : g_rest
            assign w_src[k]    = r_pipe[k-1];
            assign w_vld_in[k] = r_vld[k-1];
        end

        pipelined_cla_addsub_slice #(.SW(SW), .BLOCK(BLOCK)) u_slice (
            .i_a    (w_src[k].a[k*SW +: SW]),
            .i_b    (w_src[k].bx[k*SW +: SW]),
            .i_cin  (w_src[k].c),
            .o_sum  (w_ssum[k]),
            .o_cout (w_scout[k]),
            .o_cmsb (w_scmsb[k])
        );

        assign w_nxt[k] = '{a:  w_src[k].a,
                            bx: w_src[k].bx,
                            s:  w_src[k].s | (WIDTH'(w_ssum[k]) << (k*SW)),
                            c:  w_scout[k]};
    end

    // A stage may load when it is empty or everything downstream of it moves this cycle.
    always_comb begin
        w_rdy = '0;
        w_rdy[STAGES-1] = ~r_vld[STAGES-1] | out_ready;
        for (int k = STAGES - 2; k >= 0; k--)
            w_rdy[k] = ~r_vld[k] | w_rdy[k+1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld  <= '0;
            r_pipe <= '0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_rdy[k]) begin
                    r_vld[k] <= w_vld_in[k];
                    if (w_vld_in[k])
                        r_pipe[k] <= w_nxt[k];
                end
            end
            if (w_rdy[STAGES-1] && w_vld_in[STAGES-1]) begin
                r_ovf  <= w_scmsb[STAGES-1] ^ w_scout[STAGES-1];
                r_zero <= ~|w_nxt[STAGES-1].s;
            end
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = r_vld[STAGES-1];
    assign sum       = r_pipe[STAGES-1].s;
    assign cout      = r_pipe[STAGES-1].c;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed vector table, backpressure/reset sequences and a randomised scoreboard run.

module tb_pipelined_cla_addsub;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
    logic [W-1:0] a, b, sum;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipelined_cla_addsub #(.WIDTH(W), .BLOCK(4), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    typedef struct {
        logic [W-1:0] a, b;
        logic         cin, sub;
        logic [W-1:0] s;
        logic         c, o, z;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [34:0] model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                          input logic fcin, input logic fsub);
        logic [W-1:0] bx;
        logic         c0;
        logic [W:0]   t;
        logic [W-1:0] lo;
        bx = fsub ? ~fb : fb;
        c0 = fsub ? ~fcin : fcin;
        t  = {1'b0, fa} + {1'b0, bx} + {{W{1'b0}}, c0};
        lo = {1'b0, fa[W-2:0]} + {1'b0, bx[W-2:0]} + {{(W-1){1'b0}}, c0};
        return {t[W-1:0], t[W], lo[W-1] ^ t[W], t[W-1:0] == '0};
    endfunction

    task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db,
                         input logic dcin, input logic dsub);
        a = da; b = db; cin = dcin; sub = dsub; in_valid = 1'b1;
    endtask

    initial begin
        logic [34:0] q[$];
        logic [34:0] r1, r2, r3;
        int sent, cyc;

        //      a             b             cin   sub   sum           cout  ovf   zero
        vt[0]  = '{32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[2]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'h00000001, 1'b1, 1'b1, 1'b0};
        vt[3]  = '{32'h00000005, 32'h00000006, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vt[5]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vt[6]  = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[7]  = '{32'h00000005, 32'h00000004, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[8]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vt[10] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vt[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vt[12] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #12;
        chk("reset_hold_out", {sum, cout, ovf, zero, out_valid}, 36'h0);
        rst = 1'b0;
        tick();
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out", {sum, cout, ovf, zero, out_valid}, 36'h0);

        // Directed table: single beats, latency and result.
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub);
            chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_lat1", i), out_valid, 0);
            tick();
            chk($sformatf("vec%0d_lat2", i), out_valid, 1);
            chk($sformatf("vec%0d_result", i), {sum, cout, ovf, zero},
                {vt[i].s, vt[i].c, vt[i].o, vt[i].z});
        end
        tick();
        chk("drain_empty", out_valid, 0);

        // Backpressure: two beats fill the pipe, third is refused until release.
        out_ready = 1'b0;
        r1 = {32'h00000003, 3'b000};
        r2 = {32'h0000001E, 3'b000};
        r3 = {32'h00000065, 3'b000};
        drive(32'd1, 32'd2, 1'b0, 1'b0);
        chk("bp_rdy1", in_ready, 1);
        tick();
        drive(32'd10, 32'd20, 1'b0, 1'b0);
        chk("bp_rdy2", in_ready, 1);
        tick();
        drive(32'd100, 32'd1, 1'b0, 1'b0);
        chk("bp_full_rdy", in_ready, 0);
        chk("bp_head", {sum, cout, ovf, zero}, r1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_hold%0d", i), {in_ready, out_valid, sum, cout, ovf, zero}, {2'b01, r1});
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_beat2", {out_valid, sum, cout, ovf, zero}, {1'b1, r2});
        tick();
        chk("bp_beat3", {out_valid, sum, cout, ovf, zero}, {1'b1, r3});
        tick();
        chk("bp_done", out_valid, 0);

        // Asynchronous reset with two beats in flight.
        out_ready = 1'b0;
        drive(32'd7, 32'd8, 1'b0, 1'b0);
        tick();
        drive(32'd9, 32'd9, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("rst_pre_full", {out_valid, in_ready}, 2'b10);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_out", {out_valid, sum, cout, ovf, zero}, 36'h0);
        #3;
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_no_ghost%0d", i), out_valid, 0);
            tick();
        end

        // Randomised handshakes against the reference model.
        sent = 0;
        cyc  = 0;
        while ((sent < 2000 || q.size() != 0) && cyc < 20000) begin
            in_valid  = (sent < 2000) && ($urandom_range(0, 3) != 0);
            a         = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            b         = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = (sent >= 2000) || ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, cin, sub));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rnd_extra: got unexpected result %h expected none", sum);
                end else begin
                    chk("rnd_result", {sum, cout, ovf, zero}, q.pop_front());
                end
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("rnd_complete", {sent[15:0], 16'(q.size())}, {16'd2000, 16'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
